// File: rtl/ysyx_22050598_regfile.sv
// Integer register file: 32 x XLEN GPRs with two combinational read ports and one write port.
// Also holds the ebreak halt state, the exit-code latch, the commit counter and a debug read port.
module ysyx_22050598_regfile #(
   parameter int XLEN     = 64,
   parameter int NREG     = 32,
   parameter int BYPASS   = 1,
   parameter int EXIT_REG = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wen,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            ebreak_flag,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic            halted,
   output logic [XLEN-1:0] exit_code,
   output logic            good_trap,
   output logic [63:0]     wr_count
);

   localparam logic [4:0] EXIT_IDX = 5'(EXIT_REG);

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] regs [NREG];
   logic            commit;

   assign commit = wen && (waddr != 5'd0) && (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (state == RUN && ebreak_flag) begin
         state_next = HALTED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (commit) begin
         regs[waddr] <= wdata;
         wr_count    <= wr_count + 64'd1;
      end
   end

   // Exit code sees this edge's write to a0, so "li a0,N; ebreak" in one cycle reports N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exit_code <= '0;
      end else if (state == RUN && ebreak_flag) begin
         if (commit && waddr == EXIT_IDX) begin
            exit_code <= wdata;
         end else begin
            exit_code <= regs[EXIT_IDX];
         end
      end
   end

   assign halted    = (state == HALTED);
   assign good_trap = halted && (exit_code == '0);

   always_comb begin
      rdata1 = '0;
      if (raddr1 != 5'd0) begin
         if (BYPASS != 0 && commit && raddr1 == waddr) begin
            rdata1 = wdata;
         end else begin
            rdata1 = regs[raddr1];
         end
      end
   end

   always_comb begin
      rdata2 = '0;
      if (raddr2 != 5'd0) begin
         if (BYPASS != 0 && commit && raddr2 == waddr) begin
            rdata2 = wdata;
         end else begin
            rdata2 = regs[raddr2];
         end
      end
   end

   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_ysyx_22050598_regfile.sv
// Directed self-checking bench for ysyx_22050598_regfile.
// A second instance with BYPASS=0 shares the stimulus to cover the non-forwarding read path.
module tb_ysyx_22050598_regfile;

   logic        clk;
   logic        rst;
   logic        wen;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic        ebreak_flag;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [4:0]  dbg_addr;

   logic [63:0] rdata1, rdata2, dbg_data, exit_code, wr_count;
   logic        halted, good_trap;

   logic [63:0] nb_rdata1, nb_rdata2, nb_dbg_data, nb_exit_code, nb_wr_count;
   logic        nb_halted, nb_good_trap;

   int checks   = 0;
   int failures = 0;

   ysyx_22050598_regfile #(.BYPASS(1)) dut (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ebreak_flag(ebreak_flag), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .halted(halted), .exit_code(exit_code), .good_trap(good_trap), .wr_count(wr_count)
   );

   ysyx_22050598_regfile #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ebreak_flag(ebreak_flag), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(nb_rdata1), .rdata2(nb_rdata2), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data),
      .halted(nb_halted), .exit_code(nb_exit_code), .good_trap(nb_good_trap), .wr_count(nb_wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle's inputs just after the falling edge, leaving time to sample combinational reads.
   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic eb, input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic [4:0] da);
      @(negedge clk);
      wen         = we;
      waddr       = wa;
      wdata       = wd;
      ebreak_flag = eb;
      raddr1      = ra1;
      raddr2      = ra2;
      dbg_addr    = da;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      wen         = 1'b0;
      ebreak_flag = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; ebreak_flag = 1'b0;
      raddr1 = '0; raddr2 = '0; dbg_addr = '0;
      #12;
      rst = 1'b0;

      applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 5'd10, 5'd5);
      checkOutput("reset_rdata1", rdata1, 64'h0);
      checkOutput("reset_halted", {63'b0, halted}, 64'h0);
      checkOutput("reset_good_trap", {63'b0, good_trap}, 64'h0);
      checkOutput("reset_exit_code", exit_code, 64'h0);
      checkOutput("reset_wr_count", wr_count, 64'h0);

      applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd5, 5'd0, 5'd5);
      tick();
      checkOutput("x5_read", rdata1, 64'h1234);
      checkOutput("x5_dbg", dbg_data, 64'h1234);
      checkOutput("x5_wr_count", wr_count, 64'd1);

      applyStimulus(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("x0_no_bypass", rdata1, 64'h0);
      tick();
      checkOutput("x0_read", rdata1, 64'h0);
      checkOutput("x0_dbg", dbg_data, 64'h0);
      checkOutput("x0_wr_count", wr_count, 64'd1);

      applyStimulus(1'b1, 5'd7, 64'hAA, 1'b0, 5'd5, 5'd7, 5'd7);
      checkOutput("bypass_rdata2", rdata2, 64'hAA);
      checkOutput("bypass_rdata1_other", rdata1, 64'h1234);
      checkOutput("bypass_dbg_old", dbg_data, 64'h0);
      checkOutput("nobypass_rdata2", nb_rdata2, 64'h0);
      tick();
      checkOutput("x7_read", rdata2, 64'hAA);
      checkOutput("x7_read_nb", nb_rdata2, 64'hAA);
      checkOutput("x7_wr_count", wr_count, 64'd2);

      applyStimulus(1'b1, 5'd10, 64'h0, 1'b0, 5'd10, 5'd0, 5'd10);
      tick();
      checkOutput("x10_wr_count", wr_count, 64'd3);
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd10, 5'd0, 5'd10);
      checkOutput("pre_ebreak_halted", {63'b0, halted}, 64'h0);
      tick();
      checkOutput("ebreak_halted", {63'b0, halted}, 64'h1);
      checkOutput("ebreak_exit_code", exit_code, 64'h0);
      checkOutput("ebreak_good_trap", {63'b0, good_trap}, 64'h1);

      applyStimulus(1'b1, 5'd3, 64'd9, 1'b0, 5'd3, 5'd7, 5'd5);
      checkOutput("halted_no_bypass", rdata1, 64'h0);
      tick();
      checkOutput("halted_x3_ignored", rdata1, 64'h0);
      checkOutput("halted_read_x7", rdata2, 64'hAA);
      checkOutput("halted_dbg_x5", dbg_data, 64'h1234);
      checkOutput("halted_wr_count", wr_count, 64'd3);

      applyStimulus(1'b1, 5'd10, 64'd5, 1'b1, 5'd10, 5'd0, 5'd0);
      tick();
      checkOutput("reebreak_exit_code", exit_code, 64'h0);
      checkOutput("reebreak_x10", rdata1, 64'h0);
      checkOutput("reebreak_good_trap", {63'b0, good_trap}, 64'h1);

      applyStimulus(1'b1, 5'd6, 64'h77, 1'b0, 5'd5, 5'd7, 5'd7);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_x5", rdata1, 64'h0);
      checkOutput("async_rst_x7", rdata2, 64'h0);
      checkOutput("async_rst_dbg", dbg_data, 64'h0);
      checkOutput("async_rst_halted", {63'b0, halted}, 64'h0);
      checkOutput("async_rst_wr_count", wr_count, 64'h0);
      checkOutput("async_rst_exit_code", exit_code, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wen = 1'b0;
      raddr1 = 5'd6;
      #1;
      checkOutput("rst_write_discarded", rdata1, 64'h0);
      checkOutput("rst_write_not_counted", wr_count, 64'h0);

      applyStimulus(1'b1, 5'd4, 64'h55, 1'b0, 5'd4, 5'd0, 5'd4);
      tick();
      checkOutput("x4_read", rdata1, 64'h55);
      checkOutput("x4_wr_count", wr_count, 64'd1);
      applyStimulus(1'b1, 5'd10, 64'd3, 1'b1, 5'd10, 5'd0, 5'd10);
      checkOutput("same_cycle_bypass_a0", rdata1, 64'd3);
      tick();
      checkOutput("same_cycle_halted", {63'b0, halted}, 64'h1);
      checkOutput("same_cycle_exit_code", exit_code, 64'd3);
      checkOutput("same_cycle_good_trap", {63'b0, good_trap}, 64'h0);
      checkOutput("same_cycle_wr_count", wr_count, 64'd2);
      checkOutput("same_cycle_x10", dbg_data, 64'd3);
      checkOutput("same_cycle_nb_exit", nb_exit_code, 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22050598_regfile.md
Name: ysyx_22050598_regfile

Overview:
- Integer register file at the consumer end of the EXU writeback interface (wen/waddr/wdata); also the source of the EXU operand ports (rdata1/rdata2).
- 32 x 64-bit GPRs, two combinational read ports, one synchronous write port, x0 hardwired to zero.
- Owns the ebreak halt state machine: captures a0 (x10) as the simulation exit code and freezes architectural state.
- Provides a committed-write counter and a debug read port for the simulation harness.

Parameters:
- XLEN, 64, register width in bits.
- NREG, 32, number of architectural registers; address width is 5.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return the stored value only.
- EXIT_REG, 10, index of the register latched as the exit code (a0).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  1  write enable from EXU
- waddr  in  5  write register index
- wdata  in  XLEN  write data
- ebreak_flag  in  1  ebreak decoded this cycle
- raddr1  in  5  read port 1 index
- raddr2  in  5  read port 2 index
- rdata1  out  XLEN  read port 1 data
- rdata2  out  XLEN  read port 2 data
- dbg_addr  in  5  debug read index
- dbg_data  out  XLEN  debug read data, never bypassed
- halted  out  1  1 once ebreak has been taken
- exit_code  out  XLEN  value of EXIT_REG captured at halt
- good_trap  out  1  halted && exit_code == 0
- wr_count  out  64  number of committed register writes

Behaviour:
- Reset (async, rst=1): all GPRs = 0, state = RUN, halted = 0, exit_code = 0, good_trap = 0, wr_count = 0. Effective immediately, including mid-operation; a write in the same cycle as reset is discarded.
- Commit condition: commit = wen && waddr != 0 && state == RUN.
  - On the rising edge with commit: reg[waddr] <= wdata and wr_count <= wr_count + 1.
  - wr_count wraps from 2^64-1 to 0.
  - wen with waddr = 0 is a no-op and is not counted.
- Reads are combinational with zero latency.
  - Index 0 always returns 0.
  - If BYPASS=1 and commit is true and raddrN == waddr (nonzero), rdataN = wdata.
  - Otherwise rdataN = reg[raddrN].
  - dbg_data = reg[dbg_addr], or 0 for index 0; dbg_data is never bypassed.
- State machine, 2 states:
  - RUN: on a rising edge with ebreak_flag = 1, go to HALTED.
    - halted <= 1.
    - exit_code <= value of EXIT_REG after this edge's write: wdata if commit && waddr == EXIT_REG, else reg[EXIT_REG].
    - A write committed in the same cycle as ebreak is applied and counted.
  - HALTED: sticky until rst.
    - All writes are ignored; wr_count and exit_code are frozen.
    - No bypass is applied.
    - Further ebreak_flag pulses have no effect.
- Reads remain functional in both states.
- good_trap is combinational from the registered halted and exit_code values.

Test Plan:
- Reset, then write x5 = 0x1234 with wen=1 -> next cycle raddr1=5 gives 0x1234; wr_count = 1.
- wen=1, waddr=0, wdata=0xFFFF -> raddr1=0 reads 0; wr_count unchanged.
- BYPASS=1, same cycle wen=1, waddr=7, wdata=0xAA, raddr2=7 -> rdata2 = 0xAA combinationally, while dbg_addr=7 shows the old value 0. With BYPASS=0, rdata2 shows 0.
- Write x10 = 0, then pulse ebreak_flag -> halted=1, exit_code=0, good_trap=1. A later write x3 = 9 is ignored, x3 reads 0 and wr_count is frozen.
- Same cycle wen=1, waddr=10, wdata=3, ebreak_flag=1 -> x10 = 3, exit_code = 3, good_trap = 0, wr_count incremented.
- Assert rst asynchronously mid-run, between clock edges, after several writes -> all registers read 0 immediately; halted = 0, wr_count = 0; a write pending on that edge is discarded.
